demux_3_reg: RTL and testbench
==============================

Name: demux_3_reg

Overview:
- Registered 1-to-3 demultiplexer; the inverse of the 3-input select mux.
- Steers one signed WIDTH-bit value to one of three output channels, chosen by a 2-bit select S.
- Each output channel holds its value in a single-entry register with a valid/ack handshake.
- Used in the y86 datapath to route a computed value (valE/valM/next-PC candidate) to one of three downstream consumers.

Parameters:
- WIDTH, 64, data width in bits; data is treated as two's-complement signed.
- CNT_W, 8, width of the dropped-transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a value on X this cycle.
- in_ready  output  1  block accepts X this cycle.
- X  input  WIDTH  signed input data.
- S  input  2  channel select: 0 -> channel 1, 1 -> channel 2, 2 -> channel 3, 3 -> discard.
- Y1, Y2, Y3  output  WIDTH each  signed channel data registers.
- v1, v2, v3  output  1 each  channel holds unconsumed data.
- a1, a2, a3  input  1 each  consumer acknowledges the channel this cycle.
- drop_count  output  CNT_W  number of transfers accepted with S=3.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: on any clk edge with rst=1, Y1/Y2/Y3=0, v1/v2/v3=0, drop_count=0.
  - rst overrides all same-cycle handshakes.
  - Reset mid-operation discards held data.
  - in_ready during rst is don't-care; the bench samples it only with rst=0.
- Accept: a transfer occurs when in_valid && in_ready at a clk edge.
- in_ready is combinational from S, the valid flags and the acks:
  - S=0..2: in_ready = !vN || aN for the selected channel N, so a full channel accepts new data in the same cycle it is acked.
  - S=3: in_ready = 1.
- Channel update at a clk edge, per channel N:
  - Transfer to N: YN <= X, vN <= 1, regardless of aN.
  - Else if aN && vN: vN <= 0, and YN holds its last value.
  - Else: no change.
- Ack on an empty channel (aN=1, vN=0) has no effect.
- Latency: X appears on YN, with vN high, exactly 1 cycle after the accepting edge.
- Channel isolation: a full or stalled channel does not block transfers to the other channels. The acks a1..a3 are independent, and all three may be asserted in the same cycle.
- Discard (S=3): a transfer with S=3 changes no channel and increments drop_count by 1. drop_count saturates at 2^CNT_W-1 (no wrap).
- Data: X is stored bit-exact and sign is preserved, e.g. X=-2 gives YN = 64'hFFFF_FFFF_FFFF_FFFE.
- S and X are sampled only on the accepting edge. Changes to S or X while in_ready=0 do not affect the stored state.
- No combinational path from X to Y1..Y3.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, X=5, S=0 -> Y1..Y3=0, v1..v3=0, drop_count=0 after release.
- Routing: from empty, transfer X=1 with S=0, then X=-2 with S=1, then X=3 with S=2, with no acks.
  - Required: Y1=1, Y2=-2, Y3=3, v1=v2=v3=1.
  - Each valid rises one cycle after its accept.
  - A 4th transfer with S=0 sees in_ready=0, and Y1 stays 1.
- Backpressure with same-cycle refill: v1=1, Y1=1; apply a1=1 with in_valid=1, X=7, S=0 -> in_ready=1, and the next cycle gives Y1=7, v1=1.
  - Ack only (in_valid=0): next cycle v1=0, Y1 holds 7.
- Discard:
  - 3 transfers with S=3 -> drop_count=3; all vN and YN unchanged.
  - With CNT_W=2, 5 transfers -> drop_count stays 3 (saturation).
- Reset mid-operation: with v2=1, Y2=-2, assert rst for one cycle while also presenting a transfer on S=1 -> Y2=0, v2=0 after the edge, and the transfer is lost.
- Simultaneous acks: with all channels full, apply a1=a2=a3=1 for one cycle with in_valid=0 -> v1=v2=v3=0 next cycle, and data values hold.

Source files
------------

// File: rtl/demux_3_reg.sv
// Registered 1-to-3 demultiplexer. One signed input value is steered to one of
// three single-entry output registers, each with a valid/ack handshake. Select
// value 3 discards the transfer and bumps a saturating drop counter.
module demux_3_reg #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             a1,
  input  logic             a2,
  input  logic             a3,
  output logic [CNT_W-1:0] drop_count
);

  logic [WIDTH-1:0] y_q [3];
  logic [WIDTH-1:0] y_d [3];
  logic [2:0]       v_q, v_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [2:0] ack;
  logic [2:0] sel;
  logic       xfer;
  logic       discard;

  assign ack = {a3, a2, a1};

  // Decode the select and derive ready; a full channel being acked this cycle
  // can take new data on the same edge.
  always_comb begin
    sel      = 3'b000;
    in_ready = 1'b1;
    unique case (S)
      2'd0: begin
        sel      = 3'b001;
        in_ready = !v_q[0] || ack[0];
      end
      2'd1: begin
        sel      = 3'b010;
        in_ready = !v_q[1] || ack[1];
      end
      2'd2: begin
        sel      = 3'b100;
        in_ready = !v_q[2] || ack[2];
      end
      2'd3: begin
        sel      = 3'b000;
        in_ready = 1'b1;
      end
      default: begin
        sel      = 3'b000;
        in_ready = 1'b1;
      end
    endcase
  end

  assign xfer    = in_valid && in_ready;
  assign discard = xfer && (S == 2'd3);

  // Next-state for the channel registers and the drop counter.
  always_comb begin
    y_d    = y_q;
    v_d    = v_q;
    drop_d = drop_q;
    for (int n = 0; n < 3; n++) begin
      if (xfer && sel[n]) begin
        // A new value wins over a same-cycle ack: the old one was consumed.
        y_d[n] = X;
        v_d[n] = 1'b1;
      end else if (ack[n] && v_q[n]) begin
        v_d[n] = 1'b0;
      end
    end
    if (discard && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // State registers with synchronous reset overriding any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 3; n++) begin
        y_q[n] <= '0;
      end
      v_q    <= '0;
      drop_q <= '0;
    end else begin
      y_q    <= y_d;
      v_q    <= v_d;
      drop_q <= drop_d;
    end
  end

  assign Y1         = y_q[0];
  assign Y2         = y_q[1];
  assign Y3         = y_q[2];
  assign v1         = v_q[0];
  assign v2         = v_q[1];
  assign v3         = v_q[2];
  assign drop_count = drop_q;

endmodule

// File: tb/tb_demux_3_reg.sv
// Self-checking bench for demux_3_reg: directed scenarios followed by random
// traffic, with a queue-based channel model checked by an independent monitor.
module tb_demux_3_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] X;
  logic [1:0]  S;
  logic [63:0] Y1, Y2, Y3;
  logic        v1, v2, v3;
  logic        a1, a2, a3;
  logic [7:0]  drop_count;

  // Second instance with a 2-bit counter to exercise saturation.
  logic        s_in_ready;
  logic [63:0] s_y1, s_y2, s_y3;
  logic        s_v1, s_v2, s_v3;
  logic [1:0]  s_drop;

  int errors = 0;
  int checks = 0;

  demux_3_reg #(.WIDTH(64), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(X), .S(S),
    .Y1(Y1), .Y2(Y2), .Y3(Y3), .v1(v1), .v2(v2), .v3(v3),
    .a1(a1), .a2(a2), .a3(a3), .drop_count(drop_count)
  );

  demux_3_reg #(.WIDTH(64), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .X(X), .S(S),
    .Y1(s_y1), .Y2(s_y2), .Y3(s_y3), .v1(s_v1), .v2(s_v2), .v3(s_v3),
    .a1(a1), .a2(a2), .a3(a3), .drop_count(s_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  // Each channel is a queue of values still owed to its consumer; a channel
  // is "full" when its queue is non-empty. last[] is what the register shows.
  logic [63:0] q [3][$];
  logic [63:0] last [3];
  int          drops;
  bit          armed = 1'b0;
  logic [63:0] yv [3];
  logic [2:0]  vv, av;
  logic [63:0] got;
  bit          rdy_m;
  int          sat8, sat2;

  always_comb begin
    yv[0] = Y1;
    yv[1] = Y2;
    yv[2] = Y3;
  end
  assign vv = {v3, v2, v1};
  assign av = {a3, a2, a1};

  always @(negedge clk) begin
    if (S == 2'd3) rdy_m = 1'b1;
    else           rdy_m = (q[S].size() == 0) || av[S];
    if (armed) begin
      sat8 = (drops > 255) ? 255 : drops;
      sat2 = (drops > 3) ? 3 : drops;
      for (int n = 0; n < 3; n++) begin
        chk($sformatf("valid%0d", n + 1), {63'd0, vv[n]}, {63'd0, q[n].size() != 0});
        chk($sformatf("data%0d", n + 1), yv[n], last[n]);
      end
      chk("drop_count", {56'd0, drop_count}, 64'(sat8));
      chk("drop_count_sat", {62'd0, s_drop}, 64'(sat2));
      if (!rst) chk("in_ready", {63'd0, in_ready}, {63'd0, rdy_m});
    end
    // Advance the model across the coming rising edge.
    if (rst) begin
      for (int n = 0; n < 3; n++) begin
        q[n].delete();
        last[n] = '0;
      end
      drops = 0;
      armed = 1'b1;
    end else if (armed) begin
      for (int n = 0; n < 3; n++) begin
        if (av[n] && q[n].size() != 0) begin
          got = q[n].pop_front();
          chk($sformatf("consume%0d", n + 1), yv[n], got);
        end
      end
      if (in_valid && rdy_m) begin
        if (S == 2'd3) begin
          drops++;
        end else begin
          q[S].push_back(X);
          last[S] = X;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic iv, input logic [63:0] x,
                       input logic [1:0] s, input logic [2:0] a);
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = iv;
    X        = x;
    S        = s;
    {a3, a2, a1} = a;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 64'd0, 2'd0, 3'b000);
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; X = 64'd5; S = 2'd0; {a3, a2, a1} = 3'b000;

    // Reset held two cycles with a transfer presented.
    drive(1'b1, 1'b1, 64'd5, 2'd0, 3'b000);
    idle();
    look();
    chk("rst_y1", Y1, 64'd0);
    chk("rst_v", {61'd0, v3, v2, v1}, 64'd0);
    chk("rst_drop", {56'd0, drop_count}, 64'd0);

    // Routing to each channel, then a blocked 4th transfer.
    drive(1'b0, 1'b1, 64'd1, 2'd0, 3'b000);
    drive(1'b0, 1'b1, -64'sd2, 2'd1, 3'b000);
    look();
    chk("route_v1_after1", {63'd0, v1}, 64'd1);
    drive(1'b0, 1'b1, 64'd3, 2'd2, 3'b000);
    drive(1'b0, 1'b1, 64'd9, 2'd0, 3'b000);
    look();
    chk("route_blocked_ready", {63'd0, in_ready}, 64'd0);
    idle();
    look();
    chk("route_y1", Y1, 64'd1);
    chk("route_y2", Y2, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("route_y3", Y3, 64'd3);
    chk("route_v", {61'd0, v3, v2, v1}, 64'd7);

    // Same-cycle ack and refill on channel 1, then ack only.
    drive(1'b0, 1'b1, 64'd7, 2'd0, 3'b001);
    look();
    chk("refill_ready", {63'd0, in_ready}, 64'd1);
    idle();
    look();
    chk("refill_y1", Y1, 64'd7);
    chk("refill_v1", {63'd0, v1}, 64'd1);
    drive(1'b0, 1'b0, 64'd0, 2'd0, 3'b001);
    idle();
    look();
    chk("ack_v1", {63'd0, v1}, 64'd0);
    chk("ack_y1_hold", Y1, 64'd7);

    // Discard path and counter saturation.
    repeat (3) drive(1'b0, 1'b1, 64'd55, 2'd3, 3'b000);
    idle();
    look();
    chk("drop3", {56'd0, drop_count}, 64'd3);
    chk("drop3_y2", Y2, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("drop3_v", {61'd0, v3, v2, v1}, 64'd6);
    repeat (2) drive(1'b0, 1'b1, 64'd56, 2'd3, 3'b000);
    idle();
    look();
    chk("drop5", {56'd0, drop_count}, 64'd5);
    chk("drop5_sat2", {62'd0, s_drop}, 64'd3);

    // Reset mid-operation beats a same-cycle transfer to channel 2.
    drive(1'b1, 1'b1, 64'd11, 2'd1, 3'b000);
    idle();
    look();
    chk("midrst_y2", Y2, 64'd0);
    chk("midrst_v2", {63'd0, v2}, 64'd0);

    // Fill all three, then ack all at once.
    drive(1'b0, 1'b1, 64'd21, 2'd0, 3'b000);
    drive(1'b0, 1'b1, 64'd22, 2'd1, 3'b000);
    drive(1'b0, 1'b1, 64'd23, 2'd2, 3'b000);
    drive(1'b0, 1'b0, 64'd0, 2'd0, 3'b111);
    idle();
    look();
    chk("allack_v", {61'd0, v3, v2, v1}, 64'd0);
    chk("allack_y1", Y1, 64'd21);
    chk("allack_y3", Y3, 64'd23);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            {$urandom, $urandom}, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
    end
    // Discard-heavy phase without resets to reach 8-bit saturation.
    for (int i = 0; i < 1500; i++) begin
      drive(1'b0, 1'b1, {$urandom, $urandom},
            ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'd3,
            3'($urandom_range(0, 7)));
    end
    idle();
    look();
    chk("final_drop_sat", {56'd0, drop_count}, 64'd255);
    look();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
